// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous instruction
// memory and buffers returned words in a 2-entry queue handed to decode.
module fetch_stage #(
    parameter int D       = 12,
    parameter int W       = 9,
    parameter int HALT_PC = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    output logic [D-1:0] imem_addr,
    output logic         imem_rd_en,
    input  logic [W-1:0] imem_data,
    input  logic         reljump_en,
    input  logic         absjump_en,
    input  logic [D-1:0] target,
    output logic [W-1:0] instr_out,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [D-1:0] prog_ctr,
    output logic         done
);
    // state  | meaning
    // IDLE   | waiting for req, no fetches
    // RUN    | issuing fetches while the queue has room
    // DRAIN  | halt address reached, delivering what is left
    // HALT   | program finished, done held until req
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

    localparam logic [D-1:0] HALT_ADDR = D'(HALT_PC);

    state_t       r_state, w_state_next;
    logic [D-1:0] r_pc, w_pc_next;
    logic         r_done, w_done_next;
    logic [D-1:0] r_last_pc;
    logic [W-1:0] r_q_data [2];
    logic [D-1:0] r_q_pc   [2];
    logic         r_head;
    logic [1:0]   r_count;
    logic         r_inflight;
    logic [D-1:0] r_issue_pc;
    logic         r_kill;

    logic         w_jump, w_redirect, w_pop, w_resp, w_issue, w_tail;
    logic [D-1:0] w_jump_pc;
    logic [2:0]   w_demand;

    assign w_jump      = reljump_en | absjump_en;
    assign w_redirect  = w_jump & ((r_state == S_RUN) | (r_state == S_DRAIN));
    assign w_jump_pc   = absjump_en ? target : r_last_pc + target;
    assign instr_out   = r_q_data[r_head];
    assign instr_pc    = r_q_pc[r_head];
    assign instr_valid = (r_count != 2'd0) & ~w_jump;
    assign w_pop       = instr_valid & instr_ready;
    // A killed response belongs to a fetch issued before the last redirect.
    assign w_resp      = r_inflight & ~r_kill;
    assign w_tail      = r_head ^ r_count[0];
    assign w_demand    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == S_RUN) & ~w_redirect & (r_pc != HALT_ADDR)
                         & (w_demand < 3'd2);

    assign imem_rd_en  = w_issue;
    assign imem_addr   = r_pc;
    assign prog_ctr    = r_pc;
    assign done        = r_done;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = w_issue ? r_pc + 1'b1 : r_pc;
        w_done_next  = r_done;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_next = S_RUN;
                    w_pc_next    = '0;
                end
            end
            S_RUN: begin
                if (w_redirect) begin
                    w_pc_next = w_jump_pc;
                end else if (r_pc == HALT_ADDR) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_redirect) begin
                    w_state_next = S_RUN;
                    w_pc_next    = w_jump_pc;
                end else if ((r_count == 2'd0) && !r_inflight) begin
                    w_state_next = S_HALT;
                    w_done_next  = 1'b1;
                end
            end
            S_HALT: begin
                if (req) begin
                    w_state_next = S_RUN;
                    w_pc_next    = '0;
                    w_done_next  = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_pc  <= '0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_issue_pc <= '0;
            r_kill     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            r_inflight <= w_issue;
            r_kill     <= w_redirect & r_inflight;
            if (w_issue) begin
                r_issue_pc <= r_pc;
            end
            if (w_redirect) begin
                r_head  <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_resp) begin
                    r_q_data[w_tail] <= imem_data;
                    r_q_pc[w_tail]   <= r_issue_pc;
                end
                if (w_pop) begin
                    r_head    <= ~r_head;
                    r_last_pc <= instr_pc;
                end
                r_count <= r_count - {1'b0, w_pop} + {1'b0, w_resp};
            end
        end
    end
endmodule
